// File: rtl/div_gen_v3.sv
// ----------------------------------------------------------------------------
// div_gen_v3 : unsigned 32-bit radix-2 restoring divider, one quotient bit per
// clock, with a ready-for-data (rfd) handshake.
//
// While rfd is high the block is idle. Every rising edge in that state, with
// reset low, captures dividend/divisor and starts a division. There is no
// start strobe. Thirty-two iteration edges later the registered quotient and
// remainder are updated and rfd returns high. Results hold until the next
// completion.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high; discards any division in flight
//   dividend       [31:0] unsigned dividend, sampled while rfd = 1
//   divisor        [31:0] unsigned divisor, sampled while rfd = 1
//   rfd            ready-for-data: idle, results valid, operands sampled
//   quotient       [31:0] quotient of the last completed division
//   fractional     [31:0] remainder of the last completed division
//   divide_by_zero flag, set when the completed division had divisor 0
//                  (present only when DIV_GEN_DBZ_FLAG_EN is defined)
//
// Configuration macro: DIV_GEN_DBZ_FLAG_EN (adds the divide_by_zero output).
//
// A zero divisor needs no special case. Every trial compare against 0
// succeeds and subtracts nothing. That gives a quotient of all ones and a
// remainder equal to the dividend, with the normal latency.
// ----------------------------------------------------------------------------
module div_gen_v3 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        rfd,
  output logic [31:0] quotient,
  output logic [31:0] fractional
`ifdef DIV_GEN_DBZ_FLAG_EN
  ,
  output logic        divide_by_zero
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [5:0]  count_r, count_s;
  logic [31:0] dvd_r, dvd_s;     // dividend, shifted left one bit per iteration
  logic [31:0] dvs_r, dvs_s;     // captured divisor
  logic [32:0] rem_r, rem_s;     // partial remainder
  logic [31:0] quo_r, quo_s;     // quotient bits accumulated so far
  logic        rfd_s;
  logic [31:0] quotient_s;
  logic [31:0] fractional_s;
  logic [32:0] trial_s;
  logic        fits_s;
`ifdef DIV_GEN_DBZ_FLAG_EN
  logic        dbz_s;
`endif

  // Next-state, datapath iteration and result-load decode.
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    dvd_s        = dvd_r;
    dvs_s        = dvs_r;
    rem_s        = rem_r;
    quo_s        = quo_r;
    rfd_s        = rfd;
    quotient_s   = quotient;
    fractional_s = fractional;
`ifdef DIV_GEN_DBZ_FLAG_EN
    dbz_s        = divide_by_zero;
`endif
    // Shift the next dividend bit (MSB first) into the partial remainder.
    // The remainder is always below the divisor, so its bit 32 is always 0.
    trial_s = {rem_r[31:0], dvd_r[31]};
    fits_s  = (trial_s >= {1'b0, dvs_r});

    case (state_r)
      ST_IDLE: begin
        dvd_s   = dividend;
        dvs_s   = divisor;
        rem_s   = 33'd0;
        quo_s   = 32'd0;
        count_s = 6'd0;
        state_s = ST_BUSY;
        rfd_s   = 1'b0;
      end
      ST_BUSY: begin
        dvd_s   = {dvd_r[30:0], 1'b0};
        count_s = count_r + 6'd1;
        quo_s   = {quo_r[30:0], fits_s};
        if (fits_s) begin
          rem_s = trial_s - {1'b0, dvs_r};
        end else begin
          rem_s = trial_s;
        end
        // The 32nd iteration publishes the results and returns to idle.
        if (count_r == 6'd31) begin
          state_s      = ST_IDLE;
          rfd_s        = 1'b1;
          quotient_s   = {quo_r[30:0], fits_s};
          fractional_s = rem_s[31:0];
`ifdef DIV_GEN_DBZ_FLAG_EN
          dbz_s        = (dvs_r == 32'd0);
`endif
        end else begin
          state_s = ST_BUSY;
          rfd_s   = 1'b0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        count_s = 6'd0;
        rfd_s   = 1'b1;
      end
    endcase
  end

  // State, datapath and registered-output update; reset discards work in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      count_r    <= 6'd0;
      dvd_r      <= 32'd0;
      dvs_r      <= 32'd0;
      rem_r      <= 33'd0;
      quo_r      <= 32'd0;
      rfd        <= 1'b1;
      quotient   <= 32'd0;
      fractional <= 32'd0;
`ifdef DIV_GEN_DBZ_FLAG_EN
      divide_by_zero <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      dvd_r      <= dvd_s;
      dvs_r      <= dvs_s;
      rem_r      <= rem_s;
      quo_r      <= quo_s;
      rfd        <= rfd_s;
      quotient   <= quotient_s;
      fractional <= fractional_s;
`ifdef DIV_GEN_DBZ_FLAG_EN
      divide_by_zero <= dbz_s;
`endif
    end
  end

endmodule

// File: tb/tb_div_gen_v3.sv
// ----------------------------------------------------------------------------
// tb_div_gen_v3 : table-driven self-checking bench for div_gen_v3.
// Vectors are applied back to back. New operands go in right after each
// completion, and the operand pins are scrambled mid-busy. The bench checks
// that outputs hold while busy, and it checks latency and result spacing.
// A final hand-written sequence aborts a division with reset.
// ----------------------------------------------------------------------------
module tb_div_gen_v3;

  logic        clk;
  logic        reset;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        rfd;
  logic [31:0] quotient;
  logic [31:0] fractional;
`ifdef DIV_GEN_DBZ_FLAG_EN
  logic        divide_by_zero;
`endif

  div_gen_v3 dut (
    .clk        (clk),
    .reset      (reset),
    .dividend   (dividend),
    .divisor    (divisor),
    .rfd        (rfd),
    .quotient   (quotient),
    .fractional (fractional)
`ifdef DIV_GEN_DBZ_FLAG_EN
    ,
    .divide_by_zero (divide_by_zero)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  vec_t        vecs [8];
  int          n_tests;
  int          n_fail;
  int          cyc;
  int          last_done;
  logic [31:0] prev_q;
  logic [31:0] prev_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to measure spacing between completions.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present operands, capture them, and track the division to completion.
  task automatic run_div(input vec_t v, input logic check_gap);
    int n;
    dividend = v.a;
    divisor  = v.b;
    reset    = 1'b0;
    @(posedge clk); #1;
    check32("rfd_low_after_capture", {31'd0, rfd}, 32'd0);
    n = 0;
    while (rfd !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 5) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
      if (n == 16) begin
        check32("hold_quotient_busy", quotient, prev_q);
        check32("hold_fractional_busy", fractional, prev_r);
      end
    end
    check32("latency_edges", n, 32);
    check32("quotient", quotient, v.q);
    check32("fractional", fractional, v.r);
`ifdef DIV_GEN_DBZ_FLAG_EN
    check32("divide_by_zero", {31'd0, divide_by_zero}, {31'd0, v.dbz});
`endif
    if (check_gap) begin
      check32("completion_spacing", cyc - last_done, 33);
    end
    last_done = cyc;
    prev_q = v.q;
    prev_r = v.r;
  endtask

  initial begin
    vec_t v;
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    last_done = 0;
    prev_q    = 32'd0;
    prev_r    = 32'd0;

    vecs[0] = '{32'd100,        32'd7,        32'd14,         32'd2,      1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  32'd0,      1'b0};
    vecs[2] = '{32'hFFFF_FFFF,  32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0};
    vecs[3] = '{32'd3,          32'd10,       32'd0,          32'd3,      1'b0};
    vecs[4] = '{32'd0,          32'd5,        32'd0,          32'd0,      1'b0};
    vecs[5] = '{32'd5,          32'd0,        32'hFFFF_FFFF,  32'd5,      1'b1};
    vecs[6] = '{32'd1000,       32'd9,        32'd111,        32'd1,      1'b0};
    vecs[7] = '{32'd12345,      32'd100,      32'd123,        32'd45,     1'b0};

    reset    = 1'b1;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_rfd", {31'd0, rfd}, 32'd1);
    check32("reset_quotient", quotient, 32'd0);
    check32("reset_fractional", fractional, 32'd0);
`ifdef DIV_GEN_DBZ_FLAG_EN
    check32("reset_dbz", {31'd0, divide_by_zero}, 32'd0);
`endif

    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i], (i > 0));
    end

    // Abort 77/3 at iteration 10. After the reset, outputs must be zero and stay zero.
    dividend = 32'd77;
    divisor  = 32'd3;
    @(posedge clk); #1;
    check32("abort_rfd_busy", {31'd0, rfd}, 32'd0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check32("abort_rfd", {31'd0, rfd}, 32'd1);
    check32("abort_quotient", quotient, 32'd0);
    check32("abort_fractional", fractional, 32'd0);
    // The next division must not reveal any 77/3 result (25 r 2) while busy.
    prev_q = 32'd0;
    prev_r = 32'd0;
    v = '{32'd20, 32'd6, 32'd3, 32'd2, 1'b0};
    run_div(v, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
